imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Boot sequencer for the single-cycle MIPS core. It holds the core in reset while it receives a program image over an 8-bit valid/ready byte stream. It packs the bytes into 32-bit words and writes them into instruction memory at consecutive word addresses. After the checksum verifies, it releases the core's reset. This replaces bench-side backdoor loading of instruction memory with a synthesizable load path.

Parameters:
ADDR_W, 10, instruction-memory word-address width (1024 words).
MAX_WORDS, 1024, largest accepted image; must be <= 2**ADDR_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse that restarts a load from any state
rx_valid  in  1  byte available on rx_data
rx_data  in  8  image byte
rx_ready  out  1  loader accepts the byte this cycle
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  word to write
cpu_reset  out  1  reset to the MIPS core, active-high
done  out  1  image loaded and verified; core running
error  out  1  load failed (length or checksum); core held in reset

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Image format, big-endian:
  - LEN_HI, LEN_LO: word count N, 16 bits.
  - N×4 payload bytes, MSB of each word first.
  - One CHK byte = sum mod 256 of all preceding bytes (length bytes plus payload).
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. The state machine goes to S_LEN_HI on the first cycle after reset.
- Reset mid-load: same as above. Words already written stay in memory; memory is not cleared.
- States: S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_RUN, S_ERROR.
- A byte is accepted when rx_valid && rx_ready.
- rx_ready=1 only in S_LEN_HI, S_LEN_LO, S_DATA and S_CHECK. It is combinational from state only and never depends on rx_valid.
- Every accepted byte except CHK is added to an 8-bit running sum. The sum wraps mod 256.
- S_LEN_HI -> S_LEN_LO on accept.
- S_LEN_LO, on accept:
  - N > MAX_WORDS: go to S_ERROR.
  - N == 0: go to S_CHECK.
  - Otherwise: go to S_DATA.
- S_DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit shift register.
  - When the 4th byte of a word is accepted, imem_we=1 on the next cycle for exactly one cycle (write latency = 1 cycle). imem_addr = word index, starting at 0 and incrementing by 1. imem_wdata = the assembled word.
  - When word N-1 completes, go to S_CHECK.
- S_CHECK, on accept:
  - CHK == running sum: go to S_RUN.
  - Otherwise: go to S_ERROR.
- S_RUN: cpu_reset=0 and done=1 from the first cycle in state. The last imem write has always completed before cpu_reset falls.
- S_ERROR: error=1, cpu_reset=1, done=0.
- load_start in any state:
  - Next state is S_LEN_HI. Byte counter, word index and running sum are cleared. done=0, error=0, cpu_reset=1 on the next cycle.
  - A byte offered in the same cycle is not accepted: rx_ready is forced 0 while load_start=1.
  - A pending imem_we from the previous cycle still completes.
- Stalls: rx_valid=0 at any point leaves state, counters and sum unchanged, and imem_we=0.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Decomposition:
- Package boot_loader_pkg: state enum (S_LEN_HI..S_ERROR), BYTES_PER_WORD=4, LEN_W=16, CHK_W=8.
- One natural sub-module: imem_word_packer. It takes byte in plus accept, and outputs word_valid pulse plus word, with a clear input. The FSM, counters and checksum stay in the top module.

Test Plan:
- Nominal load of 2 words, bytes 00 02 20 01 00 0A 20 02 00 14 63 -> imem writes (addr 0, 0x2001000A) and (addr 1, 0x20020014), each with 1-cycle latency. Next: done=1, cpu_reset=0, error=0.
- Same image with CHK=0x64 -> both writes occur, then error=1, cpu_reset stays 1, done=0. A later load_start plus the correct image -> done=1.
- Length 0x0401 (1025 > MAX_WORDS) -> error=1 right after LEN_LO, no imem_we, rx_ready=0.
- N=0: bytes 00 00 00 -> no writes, done=1. Also N=1 with rx_valid toggled every other cycle -> one write, correct word, no duplicate strobes.
- Assert reset after 5 payload bytes, then send the full 2-word image -> word 0 written once per load, final done=1, addresses restart at 0.
- In S_RUN, pulse load_start together with rx_valid=1 -> cpu_reset=1 and done=0 next cycle, byte not consumed, loader in S_LEN_HI.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Defines the loader state encoding and the image-format field widths.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;
  localparam int CHK_W          = 8;

  // Running image checksum: plain byte sum that wraps mod 2**CHK_W.
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] sum,
                                               input logic [7:0]       b);
    return sum + CHK_W'(b);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Big-endian byte-to-word packer: the first accepted byte lands in word[31:24].
// word_valid is a combinational pulse on the accept of the last byte of each word.
module imem_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_p0;
  logic [23:0] shreg_p0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_p0 <= '0;
    end else if (accept) begin
      cnt_p0 <= cnt_p0 + 2'd1;
    end
  end

  // Shift register carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg_p0 <= {shreg_p0[15:0], byte_in};
    end
  end

  assign word_valid = accept && (cnt_p0 == 2'(BYTES_PER_WORD - 1));
  assign word       = {shreg_p0, byte_in};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams a length-prefixed image into
// instruction memory, verifies the byte checksum, then releases the core.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_t             state;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   len_words;
  logic [ADDR_W-1:0]  word_idx;
  logic [CHK_W-1:0]   sum;

  logic               in_load;
  logic               accept;
  logic               pack_accept;
  logic               word_valid;
  logic [31:0]        word;
  logic [LEN_W-1:0]   n_lo;
  logic               last_word;

  assign in_load     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CHECK);
  // A restart pulse masks the stream so the byte offered alongside it stays pending.
  assign rx_ready    = in_load && !load_start && !reset;
  assign accept      = rx_valid && rx_ready;
  assign pack_accept = accept && (state == S_DATA);
  assign n_lo        = {len_hi, rx_data};
  assign last_word   = word_valid && (LEN_W'(word_idx) == (len_words - LEN_W'(1)));

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .accept     (pack_accept),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_HI;
      len_hi     <= '0;
      len_words  <= '0;
      word_idx   <= '0;
      sum        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Write stage: a completed word reaches memory one cycle after its last byte.
      imem_we <= word_valid;
      if (word_valid) begin
        imem_addr  <= word_idx;
        imem_wdata <= word;
      end

      if (load_start) begin
        state     <= S_LEN_HI;
        word_idx  <= '0;
        sum       <= '0;
        done      <= 1'b0;
        error     <= 1'b0;
        cpu_reset <= 1'b1;
      end else begin
        if (accept && (state != S_CHECK)) begin
          sum <= chk_add(sum, rx_data);
        end
        if (word_valid) begin
          word_idx <= word_idx + ADDR_W'(1);
        end

        case (state)
          S_LEN_HI: begin
            if (accept) begin
              len_hi <= rx_data;
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (accept) begin
              len_words <= n_lo;
              if (n_lo > LEN_W'(MAX_WORDS)) begin
                state <= S_ERROR;
                error <= 1'b1;
              end else if (n_lo == '0) begin
                state <= S_CHECK;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (last_word) begin
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            // The last write strobe is already out by the time CHK can be accepted,
            // so releasing the core here never races the final memory write.
            if (accept) begin
              if (rx_data == sum) begin
                state     <= S_RUN;
                cpu_reset <= 1'b0;
                done      <= 1'b1;
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end
          end
          S_RUN, S_ERROR: begin
          end
          default: begin
            state <= S_LEN_HI;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued from
// a byte-level image model, and a monitor compares every write strobe.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] img_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h required=none", imem_addr, imem_wdata);
        end else begin
          e = wq.pop_front();
          chk("write_addr", 32'(imem_addr), 32'(e.addr));
          chk("write_data", imem_wdata, e.data);
        end
        chk("cpu_reset_during_write", 32'(cpu_reset), 32'd1);
      end
    end
  end

  // All tasks are entered just after a falling edge, where inputs are driven.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bit   ok;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      #1 acc = rx_ready;
      @(negedge clk);
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Reference model works on the whole image: length, words, byte-sum checksum.
  task automatic run_image(input int gap, input bit do_start);
    int         n;
    int         nsend;
    logic [7:0] s;
    bit         exp_ok;
    bit         seen;
    wr_t        w;
    if (do_start) pulse_load_start();
    n = {img_q[0], img_q[1]};
    if (n > MAX_WORDS) begin
      exp_ok = 0;
      nsend  = 2;
    end else begin
      s = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) s = s + img_q[i];
      for (int i = 0; i < n; i++) begin
        w.addr = ADDR_W'(i);
        w.data = {img_q[2+4*i], img_q[3+4*i], img_q[4+4*i], img_q[5+4*i]};
        wq.push_back(w);
      end
      exp_ok = (img_q[2 + 4 * n] == s);
      nsend  = 3 + 4 * n;
    end
    for (int i = 0; i < nsend; i++)
      send_byte(img_q[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    rx_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (done || error) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("status_seen", 32'(seen), 32'd1);
    chk("done", 32'(done), 32'(exp_ok));
    chk("error", 32'(error), 32'(!exp_ok));
    chk("cpu_reset", 32'(cpu_reset), 32'(!exp_ok));
    chk("rx_ready_idle", 32'(rx_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("writes_drained", 32'(wq.size()), 32'd0);
  endtask

  task automatic load_nominal(input logic [7:0] chkb);
    img_q = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A, 8'h20, 8'h02, 8'h00, 8'h14, chkb};
  endtask

  initial begin
    wr_t w;
    int  n;
    logic [7:0] s;
    reset      = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("len_hi_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);

    // Nominal two-word image.
    load_nominal(8'h63);
    run_image(0, 1);

    // Bad checksum, then recovery with the correct image.
    load_nominal(8'h64);
    run_image(0, 1);
    pulse_load_start();
    #1;
    chk("restart_error_clr", 32'(error), 32'd0);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    load_nominal(8'h63);
    run_image(0, 1);

    // Over-long length field.
    img_q = '{8'h04, 8'h01};
    run_image(0, 1);

    // Empty image.
    img_q = '{8'h00, 8'h00, 8'h00};
    run_image(0, 1);

    // One word, rx_valid toggled every other cycle.
    img_q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    img_q[6] = 8'h01 + 8'hDE + 8'hAD + 8'hBE + 8'hEF;
    run_image(1, 1);

    // Reset after five payload bytes, then a full reload.
    pulse_load_start();
    load_nominal(8'h63);
    w.addr = '0;
    w.data = 32'h2001000A;
    wq.push_back(w);
    for (int i = 0; i < 7; i++) send_byte(img_q[i], 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_word0_written", 32'(wq.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_image(0, 0);

    // load_start in S_RUN together with an offered byte.
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'h00;
    #1 chk("start_masks_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    rx_valid   = 1'b0;
    #1;
    chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_in_len_hi", 32'(rx_ready), 32'd1);
    @(negedge clk);
    load_nominal(8'h63);
    run_image(0, 0);

    // Randomized images with random stalls, bad checksums and bad lengths.
    for (int r = 0; r < 10; r++) begin
      img_q.delete();
      if (r == 3 || r == 7) begin
        n = int'($urandom_range(MAX_WORDS + 1, 65535));
        img_q.push_back(8'(n >> 8));
        img_q.push_back(8'(n));
      end else begin
        n = int'($urandom_range(0, 5));
        img_q.push_back(8'(n >> 8));
        img_q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img_q.push_back(8'($urandom_range(0, 255)));
        s = 8'h00;
        foreach (img_q[i]) s = s + img_q[i];
        if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
        img_q.push_back(s);
      end
      run_image(-1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
